// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
module mips_muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    localparam int ITER = WIDTH / UNROLL;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hw_q, hw_d, lw_q, lw_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic               dbz_pend_q, dbz_pend_d, dbz_q, dbz_d;

    logic               accept, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, sh, sl;
    logic [WIDTH:0]     sum, shifted;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = req_valid && (state_q == S_IDLE) && !flush;
    assign signed_op = !req_op[2] && !req_op[0];
    assign a_neg     = signed_op && req_a[WIDTH-1];
    assign b_neg     = signed_op && req_b[WIDTH-1];
    assign a_mag     = a_neg ? -req_a : req_a;
    assign b_mag     = b_neg ? -req_b : req_b;
    assign prod_fix  = neg_q ? -{hw_q, lw_q} : {hw_q, lw_q};

    // Working pair {sh,sl}: product accumulates right-shifting; division shifts dividend bits left into sh.
    always_comb begin
        sh      = hw_q;
        sl      = lw_q;
        sum     = '0;
        shifted = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div_q) begin
                shifted = {sh, sl[WIDTH-1]};
                if (shifted >= {1'b0, opnd_q}) begin
                    shifted = shifted - {1'b0, opnd_q};
                    sl      = {sl[WIDTH-2:0], 1'b1};
                end else begin
                    sl      = {sl[WIDTH-2:0], 1'b0};
                end
                sh = shifted[WIDTH-1:0];
            end else begin
                sum = {1'b0, sh} + (sl[0] ? {1'b0, opnd_q} : '0);
                sl  = {sum[0], sl[WIDTH-1:1]};
                sh  = sum[WIDTH:1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hw_d       = hw_q;
        lw_d       = lw_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (req_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            dbz_d      = 1'b0;
                            is_div_d   = req_op[1];
                            neg_d      = a_neg ^ b_neg;
                            cnt_d      = '0;
                            hw_d       = '0;
                            dbz_pend_d = 1'b0;
                            state_d    = S_CALC;
                            if (req_op[1]) begin
                                lw_d      = a_mag;
                                opnd_d    = b_mag;
                                neg_rem_d = a_neg;
                                if (req_b == '0) begin
                                    hw_d       = req_a;
                                    lw_d       = '1;
                                    neg_d      = 1'b0;
                                    neg_rem_d  = 1'b0;
                                    dbz_pend_d = 1'b1;
                                    state_d    = S_FIX;
                                end
                            end else begin
                                lw_d      = b_mag;
                                opnd_d    = a_mag;
                                neg_rem_d = 1'b0;
                            end
                        end
                        3'd4:    hi_d = req_a;
                        3'd5:    lo_d = req_a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                hw_d  = sh;
                lw_d  = sl;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q ? -lw_q : lw_q;
                    hi_d = neg_rem_q ? -hw_q : hw_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                dbz_d   = dbz_pend_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over a same-edge commit so an aborted op never touches HI/LO.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hw_q       <= '0;
            lw_q       <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hw_q       <= hw_d;
            lw_q       <= lw_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
